// File: rtl/spi_bus_arbiter.sv
// Transaction-level arbiter that shares one spi_master byte engine between N_REQ requesters.
// It owns every chip select and grants whole CS-low windows round-robin, with CS setup and release-gap timing.
module spi_bus_arbiter #(
    parameter int N_REQ    = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_GAP   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_start,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   req_done,
    output logic [7:0]         rx_data,
    output logic [N_REQ-1:0]   spi_cs_n,
    output logic               m_start,
    output logic [7:0]         m_data_in,
    input  logic               m_busy,
    input  logic               m_done,
    input  logic [7:0]         m_data_out
);

    localparam int CNT_MAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
    localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int OW      = $clog2(N_REQ);

    localparam logic [CW-1:0] SETUP_LAST = CW'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
    localparam logic [CW-1:0] GAP_LAST   = CW'((CS_GAP > 0) ? CS_GAP - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACTIVE,
        ST_DRAIN,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    rr_last_q, rr_last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] cs_n_q, cs_n_d;
    logic             m_start_q, m_start_d;
    logic [7:0]       m_data_in_q, m_data_in_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             in_flight_q, in_flight_d;

    logic [N_REQ-1:0] owner_oh;
    logic             done_live;
    logic             found;
    logic [OW-1:0]    pick;

    assign owner_oh  = N_REQ'(1) << owner_q;
    // A completion only belongs to the current owner while its CS window is still open.
    assign done_live = m_done && (state_q == ST_ACTIVE || state_q == ST_DRAIN);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        cs_n_d      = cs_n_q;
        m_start_d   = 1'b0;
        m_data_in_d = m_data_in_q;
        rx_data_d   = rx_data_q;
        in_flight_d = in_flight_q;
        found       = 1'b0;
        pick        = '0;

        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req[(int'(rr_last_q) + k) % N_REQ]) begin
                found = 1'b1;
                pick  = OW'((int'(rr_last_q) + k) % N_REQ);
            end
        end

        if (done_live) begin
            in_flight_d = 1'b0;
            rx_data_d   = m_data_out;
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    owner_d = pick;
                    cs_n_d  = ~(N_REQ'(1) << pick);
                    cnt_d   = '0;
                    if (CS_SETUP == 0) begin
                        gnt_d   = N_REQ'(1) << pick;
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    gnt_d   = owner_oh;
                    cnt_d   = '0;
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACTIVE: begin
                // Starts while a byte is outstanding are dropped, never queued.
                if (req_start[owner_q] && !in_flight_q && !m_busy) begin
                    m_start_d   = 1'b1;
                    m_data_in_d = req_data[{owner_q, 3'b000} +: 8];
                    in_flight_d = 1'b1;
                end
                if (!req[owner_q]) begin
                    gnt_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!in_flight_q && !m_busy) begin
                    cs_n_d    = '1;
                    rr_last_d = owner_q;
                    cnt_d     = '0;
                    state_d   = (CS_GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cs_n_d  = '1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_last_q   <= OW'(N_REQ - 1);
            cnt_q       <= '0;
            gnt_q       <= '0;
            cs_n_q      <= '1;
            m_start_q   <= 1'b0;
            m_data_in_q <= '0;
            rx_data_q   <= '0;
            in_flight_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            cs_n_q      <= cs_n_d;
            m_start_q   <= m_start_d;
            m_data_in_q <= m_data_in_d;
            rx_data_q   <= rx_data_d;
            in_flight_q <= in_flight_d;
        end
    end

    // The live byte is forwarded so rx_data is already valid in the req_done cycle.
    assign rx_data   = done_live ? m_data_out : rx_data_q;
    assign req_done  = done_live ? owner_oh : '0;
    assign gnt       = gnt_q;
    assign spi_cs_n  = cs_n_q;
    assign m_start   = m_start_q;
    assign m_data_in = m_data_in_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed steps plus randomized rounds checked against a
// transaction-level round-robin model and a behavioural spi_master byte engine.
module tb_spi_bus_arbiter;

    localparam int N        = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_GAP   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   req_start;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   req_done;
    logic [7:0]     rx_data;
    logic [N-1:0]   spi_cs_n;
    logic           m_start;
    logic [7:0]     m_data_in;
    logic           m_busy     = 1'b0;
    logic           m_done     = 1'b0;
    logic [7:0]     m_data_out = 8'h00;

    int   vectors     = 0;
    int   miscompares = 0;
    int   starts      = 0;
    int   lat         = 0;
    logic [7:0] shift_q = 8'h00;
    int   last_owner  = N - 1;
    bit   mon_en      = 1'b0;

    spi_bus_arbiter #(
        .N_REQ   (N),
        .CS_SETUP(CS_SETUP),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_start (req_start),
        .req_data  (req_data),
        .gnt       (gnt),
        .req_done  (req_done),
        .rx_data   (rx_data),
        .spi_cs_n  (spi_cs_n),
        .m_start   (m_start),
        .m_data_in (m_data_in),
        .m_busy    (m_busy),
        .m_done    (m_done),
        .m_data_out(m_data_out)
    );

    // Byte engine: busy for a random number of cycles, answers with the sent byte xor 0xE1.
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (m_busy) begin
            if (lat <= 1) begin
                m_busy     <= 1'b0;
                m_done     <= 1'b1;
                m_data_out <= shift_q ^ 8'hE1;
            end else begin
                lat <= lat - 1;
            end
        end else if (m_start) begin
            m_busy  <= 1'b1;
            lat     <= int'($urandom_range(2, 6));
            shift_q <= m_data_in;
            starts  <= starts + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] s, input logic [8*N-1:0] d);
        req       = r;
        req_start = s;
        req_data  = d;
    endtask

    // At most one CS low, and a grant only ever sits on the device whose CS is low.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("cs_onehot", {31'b0, $onehot0(~spi_cs_n)}, 32'd1);
            checkOutput("gnt_cs", {31'b0, ((gnt & spi_cs_n) == '0) && $onehot0(gnt)}, 32'd1);
        end
    end

    function automatic int pickNext(input logic [N-1:0] pending, input int last);
        pickNext = -1;
        for (int k = 1; k <= N; k++) begin
            int idx = (last + k) % N;
            if (pickNext < 0 && pending[idx]) pickNext = idx;
        end
    endfunction

    function automatic int ownerOf(input logic [N-1:0] g);
        ownerOf = -1;
        for (int j = 0; j < N; j++) if (g[j]) ownerOf = j;
    endfunction

    task automatic applyReset();
        rst_n = 1'b0;
        applyStimulus('0, '0, '0);
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        last_owner = N - 1;
    endtask

    task automatic waitGrant(output int owner);
        int n = 0;
        while (gnt === '0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        owner = ownerOf(gnt);
        if (owner < 0) checkOutput("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDone(input int idx);
        bit got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (req_done[idx]) got = 1'b1;
        end
        if (!got) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic sendByte(input int owner, input logic [7:0] data);
        int           s0;
        logic [N-1:0] exp_done;
        logic [7:0]   exp_rx;
        s0 = starts;
        req_start = '0;
        req_start[owner] = 1'b1;
        req_data[owner*8 +: 8] = data;
        for (int j = 0; j < N; j++) begin
            if (j != owner && $urandom_range(0, 1) == 1) begin
                req_start[j] = 1'b1;
                req_data[j*8 +: 8] = 8'($urandom);
            end
        end
        @(negedge clk);
        req_start = '0;
        checkOutput("m_start", {31'b0, m_start}, 32'd1);
        checkOutput("m_data_in", {24'b0, m_data_in}, {24'b0, data});
        if ($urandom_range(0, 1) == 1) begin
            req_start[owner] = 1'b1;
            req_data[owner*8 +: 8] = ~data;
            @(negedge clk);
            req_start = '0;
            checkOutput("overrun_dropped", {31'b0, m_start}, 32'd0);
        end
        waitDone(owner);
        exp_done = N'(1) << owner;
        exp_rx   = data ^ 8'hE1;
        checkOutput("req_done", {30'b0, req_done}, {30'b0, exp_done});
        checkOutput("rx_data_live", {24'b0, rx_data}, {24'b0, exp_rx});
        @(negedge clk);
        checkOutput("rx_data_hold", {24'b0, rx_data}, {24'b0, exp_rx});
        checkOutput("starts_per_byte", starts - s0, 32'd1);
    endtask

    task automatic runRound(input logic [N-1:0] after_mask, input int nbytes, output int owner);
        int           expected;
        logic [N-1:0] exp_cs;
        expected = pickNext(req, last_owner);
        waitGrant(owner);
        checkOutput("grant_owner", owner, expected);
        if (owner < 0) return;
        exp_cs = ~(N'(1) << owner);
        checkOutput("cs_of_owner", {30'b0, spi_cs_n}, {30'b0, exp_cs});
        for (int b = 0; b < nbytes; b++) sendByte(owner, 8'($urandom));
        req[owner] = 1'b0;
        @(negedge clk);
        req        = req | after_mask;
        last_owner = owner;
    endtask

    initial begin
        int   owner;
        int   n;
        int   high;
        bit   cs_held;
        bit   got;
        bit   any_done;

        applyReset();
        checkOutput("rst_gnt", {30'b0, gnt}, 32'd0);
        checkOutput("rst_cs_n", {30'b0, spi_cs_n}, 32'd3);
        checkOutput("rst_m_start", {31'b0, m_start}, 32'd0);
        checkOutput("rst_m_data_in", {24'b0, m_data_in}, 32'd0);
        checkOutput("rst_rx_data", {24'b0, rx_data}, 32'd0);
        checkOutput("rst_req_done", {30'b0, req_done}, 32'd0);
        mon_en = 1'b1;

        // Single owner: CS low one clock after req, grant CS_SETUP clocks later.
        req = 2'b01;
        @(negedge clk);
        checkOutput("single_cs_p1", {30'b0, spi_cs_n}, 32'd2);
        checkOutput("single_gnt_p1", {30'b0, gnt}, 32'd0);
        @(negedge clk);
        checkOutput("single_gnt_p2", {30'b0, gnt}, 32'd0);
        @(negedge clk);
        checkOutput("single_gnt_p3", {30'b0, gnt}, 32'd1);
        req_start = 2'b10;
        req_data  = 16'h7700;
        @(negedge clk);
        req_start = '0;
        checkOutput("non_owner_start", {31'b0, m_start}, 32'd0);
        sendByte(0, 8'hBB);
        checkOutput("rx_5a", {24'b0, rx_data}, 32'h5A);
        req = '0;
        repeat (10) @(negedge clk);

        // Contention straight out of reset: requester 0 first, then requester 1.
        applyReset();
        req = 2'b11;
        runRound('0, 1, owner);
        checkOutput("contention_first", owner, 32'd0);
        runRound('0, 1, owner);
        checkOutput("contention_second", owner, 32'd1);

        // Both requesters re-raising immediately must alternate.
        req = '1;
        for (int i = 0; i < 6; i++) begin
            runRound('1, 1, owner);
            checkOutput("fair_alt", owner, i % 2);
        end

        for (int i = 0; i < 10; i++) begin
            if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
            runRound(N'($urandom_range(0, (1 << N) - 1)), int'($urandom_range(1, 3)), owner);
        end
        n = 0;
        while (req != '0 && n < 8) begin
            runRound('0, 1, owner);
            n++;
        end

        // Owner drops req mid-byte: CS held until completion, then the release gap.
        req = 2'b01;
        waitGrant(owner);
        checkOutput("drop_owner", owner, 32'd0);
        req_start = 2'b01;
        req_data  = 16'h003C;
        @(negedge clk);
        req_start = '0;
        n = 0;
        while (!m_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        req     = 2'b10;
        cs_held = 1'b1;
        got     = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (spi_cs_n[0] !== 1'b0) cs_held = 1'b0;
            if (req_done[0]) got = 1'b1;
        end
        checkOutput("drop_done", {31'b0, got}, 32'd1);
        checkOutput("drop_cs_held", {31'b0, cs_held}, 32'd1);
        checkOutput("drop_rx", {24'b0, rx_data}, 32'h3C ^ 32'hE1);
        n = 0;
        while (spi_cs_n !== '1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        high = 0;
        while (spi_cs_n === '1 && high < 30) begin
            @(negedge clk);
            high++;
        end
        // All CS high for the gap plus the single arbitration cycle in IDLE.
        checkOutput("gap_cycles", high, CS_GAP + 1);
        checkOutput("next_cs", {30'b0, spi_cs_n}, 32'd1);
        last_owner = 0;
        runRound('0, 1, owner);
        checkOutput("after_drop_owner", owner, 32'd1);

        // Reset while a byte is in flight aborts the window without a completion.
        req = 2'b01;
        waitGrant(owner);
        req_start = 2'b01;
        req_data  = 16'h00A5;
        @(negedge clk);
        req_start = '0;
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst_gnt", {30'b0, gnt}, 32'd0);
        checkOutput("midrst_cs_n", {30'b0, spi_cs_n}, 32'd3);
        checkOutput("midrst_m_start", {31'b0, m_start}, 32'd0);
        any_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (req_done != '0) any_done = 1'b1;
        end
        checkOutput("midrst_no_done", {31'b0, any_done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
